bin2bcd_conv: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3, one bit per clock) that

---
 rtl/bin2bcd_conv.sv | 146 ++++++++++++++
 tb/tb_bin2bcd_conv.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_conv.sv
// -----------------------------------------------------------------------------
// bin2bcd_conv
//   Sequential binary-to-BCD converter using the shift-add-3 (double dabble)
//   algorithm, one binary bit per clock. Produces a packed BCD word for the
//   seven-segment display path. Values above 10^DIGITS-1 saturate to all-9
//   digits and raise overflow.
//
// Parameters
//   BIN_W   width of the unsigned binary input (1..4*DIGITS)
//   DIGITS  number of BCD digits produced
//
// Ports
//   sys_clk   in   1          system clock, rising edge
//   rst_n     in   1          asynchronous active-low reset
//   start     in   1          conversion request, only honoured while idle
//   bin_in    in   BIN_W      binary value, captured when start is accepted
//   busy      out  1          high from accept through the DONE state cycle
//   done      out  1          one-cycle pulse: bcd_out/overflow just updated
//   bcd_out   out  4*DIGITS   packed BCD result, digit 0 in [3:0]
//   overflow  out  1          last captured value exceeded 10^DIGITS-1
// -----------------------------------------------------------------------------
module bin2bcd_conv #(
    parameter int BIN_W  = 20,
    parameter int DIGITS = 6
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [63:0]      MAX_VAL  = 64'(10 ** DIGITS) - 64'd1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [BIN_W-1:0]   shift_reg, shift_next;
    logic [BCD_W-1:0]   work_reg, work_next;
    logic [BCD_W-1:0]   work_adj;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               ovf_reg, ovf_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic [BCD_W-1:0]   bcd_out_reg, bcd_out_next;
    logic               overflow_reg, overflow_next;
    logic [BCD_W+BIN_W-1:0] shifted;

    // Add-3 correction on every nibble in parallel. A nibble never exceeds 9
    // before correction, so the 4-bit sum cannot carry into the next digit.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5)
                                       ? work_reg[4*gi +: 4] + 4'd3
                                       : work_reg[4*gi +: 4];
        end
    endgenerate

    // Combined {bcd, binary} left shift: binary MSB enters BCD bit 0.
    assign shifted = {work_adj, shift_reg} << 1;

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        work_next     = work_reg;
        cnt_next      = cnt_reg;
        ovf_next      = ovf_reg;
        done_next     = 1'b0;
        bcd_out_next  = bcd_out_reg;
        overflow_next = overflow_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    shift_next = bin_in;
                    work_next  = '0;
                    cnt_next   = '0;
                    ovf_next   = (64'(bin_in) > MAX_VAL);
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                work_next  = shifted[BCD_W+BIN_W-1:BIN_W];
                shift_next = shifted[BIN_W-1:0];
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == LAST_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Saturate instead of showing a wrapped value.
                bcd_out_next  = ovf_reg ? {DIGITS{4'h9}} : work_reg;
                overflow_next = ovf_reg;
                done_next     = 1'b1;
                state_next    = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // busy is registered from the next state so it rises on the accept
        // edge and falls on the edge that leaves DONE.
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            shift_reg    <= '0;
            work_reg     <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            bcd_out_reg  <= '0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            work_reg     <= work_next;
            cnt_reg      <= cnt_next;
            ovf_reg      <= ovf_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            bcd_out_reg  <= bcd_out_next;
            overflow_reg <= overflow_next;
        end
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign bcd_out  = bcd_out_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_bin2bcd_conv.sv
// -----------------------------------------------------------------------------
// tb_bin2bcd_conv
//   Self-checking bench for bin2bcd_conv (BIN_W=20, DIGITS=6). Expected BCD
//   values come from a decimal-digit reference model using division/modulo.
// -----------------------------------------------------------------------------
module tb_bin2bcd_conv;

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        start   = 1'b0;
    logic [19:0] bin_in  = '0;
    logic        busy;
    logic        done;
    logic [23:0] bcd_out;
    logic        overflow;

    int tests = 0;
    int fails = 0;

    always #5 sys_clk = ~sys_clk;

    bin2bcd_conv #(.BIN_W(20), .DIGITS(6)) dut (
        .sys_clk  (sys_clk),
        .rst_n    (rst_n),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
    );

    // Reference model: decimal digits by division, saturating at 999999.
    function automatic logic [23:0] ref_bcd(input logic [19:0] v);
        logic [23:0] r;
        int unsigned x;
        if (v > 20'd999999) return 24'h999999;
        x = v;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input logic [19:0] v);
        return (v > 20'd999999);
    endfunction

    // Starts one conversion from idle and waits (bounded) for done.
    // lat counts rising edges after the accept edge until done is seen.
    task automatic do_conv(input logic [19:0] v, input int poke_at,
                           output logic [23:0] got_bcd, output logic got_ovf,
                           output int lat, output int busy_cyc,
                           output logic busy_at_done, output bit stable);
        logic [23:0] hold_bcd;
        logic        hold_ovf;
        @(negedge sys_clk);
        hold_bcd = bcd_out;
        hold_ovf = overflow;
        start  = 1'b1;
        bin_in = v;
        @(negedge sys_clk);
        start  = 1'b0;
        bin_in = 20'($urandom);
        lat = 0; busy_cyc = 0; stable = 1'b1;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) busy_cyc++;
            if (bcd_out !== hold_bcd || overflow !== hold_ovf) stable = 1'b0;
            if (lat == poke_at) begin
                start  = 1'b1;
                bin_in = 20'd42;
            end else if (lat == poke_at + 1) begin
                start = 1'b0;
            end
            @(negedge sys_clk);
            lat++;
        end
        start        = 1'b0;
        got_bcd      = bcd_out;
        got_ovf      = overflow;
        busy_at_done = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        tests++;
        if ({busy, done, overflow, bcd_out} !== 27'd0) begin
            fails++;
            $display("FAIL reset_outputs: busy=%b done=%b ovf=%b bcd=%h, want all 0",
                     busy, done, overflow, bcd_out);
        end
        rst_n = 1'b1;
        @(negedge sys_clk);
        $display("[TB] reset: busy=%b done=%b bcd=%h", busy, done, bcd_out);
    endtask

    task automatic test_zero();
        logic [23:0] b; logic o, bd; int lat, bc; bit st;
        do_conv(20'd0, -10, b, o, lat, bc, bd, st);
        $display("[TB] zero: bcd=%h ovf=%b lat=%0d busy_cyc=%0d", b, o, lat, bc);
        tests++;
        if (lat != 21) begin fails++; $display("FAIL zero_latency: got %0d want 21", lat); end
        tests++;
        if (bc != 21) begin fails++; $display("FAIL zero_busy_cycles: got %0d want 21", bc); end
        tests++;
        if (bd !== 1'b0) begin fails++; $display("FAIL zero_busy_at_done: got %b want 0", bd); end
        tests++;
        if (b !== 24'h000000 || o !== 1'b0) begin
            fails++; $display("FAIL zero_result: got %h/%b want 000000/0", b, o);
        end
        @(negedge sys_clk);
        tests++;
        if (done !== 1'b0) begin fails++; $display("FAIL zero_done_pulse_width: done=%b want 0", done); end
    endtask

    task automatic test_values();
        logic [19:0] vals [4];
        logic [23:0] b; logic o, bd; int lat, bc; bit st;
        vals = '{20'd123456, 20'd999999, 20'd1000000, 20'hFFFFF};
        foreach (vals[i]) begin
            do_conv(vals[i], -10, b, o, lat, bc, bd, st);
            $display("[TB] value %0d: bcd=%h ovf=%b lat=%0d", vals[i], b, o, lat);
            tests++;
            if (b !== ref_bcd(vals[i]) || o !== ref_ovf(vals[i])) begin
                fails++;
                $display("FAIL value_%0d: got %h/%b want %h/%b",
                         vals[i], b, o, ref_bcd(vals[i]), ref_ovf(vals[i]));
            end
            tests++;
            if (lat != 21) begin fails++; $display("FAIL value_latency_%0d: got %0d want 21", vals[i], lat); end
            tests++;
            if (!st) begin fails++; $display("FAIL value_stable_%0d: outputs changed before done, want held", vals[i]); end
        end
    endtask

    task automatic test_ignore_start();
        logic [19:0] v;
        logic [23:0] b; logic o, bd; int lat, bc, extra; bit st;
        v = 20'($urandom_range(0, 999999));
        do_conv(v, 5, b, o, lat, bc, bd, st);
        $display("[TB] ignore: v=%0d bcd=%h lat=%0d", v, b, lat);
        tests++;
        if (b !== ref_bcd(v) || o !== 1'b0) begin
            fails++; $display("FAIL ignore_result: got %h/%b want %h/0", b, o, ref_bcd(v));
        end
        tests++;
        if (lat != 21) begin fails++; $display("FAIL ignore_latency: got %0d want 21", lat); end
        extra = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (done === 1'b1) extra++;
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL ignore_extra_done: got %0d pulses want 0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [19:0] v;
        int t [$];
        int cyc, bad;
        v = 20'($urandom_range(0, 999999));
        bad = 0;
        @(negedge sys_clk);
        start  = 1'b1;
        bin_in = v;
        for (cyc = 1; cyc <= 70; cyc++) begin
            @(negedge sys_clk);
            if (done === 1'b1) begin
                t.push_back(cyc);
                if (bcd_out !== ref_bcd(v)) bad++;
            end
        end
        start = 1'b0;
        $display("[TB] back_to_back: v=%0d dones=%0d", v, t.size());
        tests++;
        if (t.size() != 3) begin
            fails++; $display("FAIL b2b_count: got %0d dones want 3", t.size());
        end else begin
            tests++;
            if (t[0] != 22 || t[1] - t[0] != 22 || t[2] - t[1] != 22) begin
                fails++;
                $display("FAIL b2b_period: got done at %0d,%0d,%0d want 22,44,66", t[0], t[1], t[2]);
            end
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL b2b_result: %0d wrong results want 0", bad); end
        repeat (25) @(negedge sys_clk);
    endtask

    task automatic test_reset_abort();
        logic [23:0] b; logic o, bd; int lat, bc, extra; bit st;
        do_conv(20'd123456, -10, b, o, lat, bc, bd, st);
        @(negedge sys_clk);
        start  = 1'b1;
        bin_in = 20'd777;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (10) @(negedge sys_clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({busy, done, overflow, bcd_out} !== 27'd0) begin
            fails++;
            $display("FAIL abort_outputs: busy=%b done=%b ovf=%b bcd=%h, want all 0",
                     busy, done, overflow, bcd_out);
        end
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        extra = 0;
        repeat (30) begin
            @(negedge sys_clk);
            if (done === 1'b1) extra++;
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL abort_done: got %0d pulses want 0", extra); end
        do_conv(20'd555, -10, b, o, lat, bc, bd, st);
        $display("[TB] abort then 555: bcd=%h ovf=%b lat=%0d", b, o, lat);
        tests++;
        if (b !== 24'h000555 || o !== 1'b0) begin
            fails++; $display("FAIL abort_restart: got %h/%b want 000555/0", b, o);
        end
    endtask

    task automatic test_random_sweep();
        logic [19:0] v;
        logic [23:0] b; logic o, bd; int lat, bc; bit st;
        for (int n = 0; n < 2000; n++) begin
            v = 20'($urandom_range(0, 20'hFFFFF));
            do_conv(v, -10, b, o, lat, bc, bd, st);
            tests++;
            if (b !== ref_bcd(v) || o !== ref_ovf(v) || lat != 21) begin
                fails++;
                $display("FAIL random_%0d: v=%0d got %h/%b lat %0d want %h/%b lat 21",
                         n, v, b, o, lat, ref_bcd(v), ref_ovf(v));
            end
            tests++;
            if (!st) begin fails++; $display("FAIL random_stable_%0d: outputs changed before done, want held", n); end
        end
        $display("[TB] random sweep: 2000 conversions checked");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_values();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_random_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
